// File: rtl/axis_stream_chain.sv
// axis_stream_chain: counting AXI4-Stream source -> one-stage skid buffer ->
// sink with periodic backpressure, beat counting and sequence checking.
// The mon_* outputs expose the pipe-to-sink stream (tfirst is internal only).
module axis_stream_chain #(
  parameter int AXIS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [AXIS_WIDTH-1:0] init_data,
  output logic                  mon_tvalid,
  output logic                  mon_tready,
  output logic [AXIS_WIDTH-1:0] mon_tdata,
  output logic [31:0]           beat_count,
  output logic [AXIS_WIDTH-1:0] last_data,
  output logic                  seq_error
);

  localparam logic [AXIS_WIDTH-1:0] DATA_ZERO = {AXIS_WIDTH{1'b0}};
  localparam logic [AXIS_WIDTH-1:0] DATA_ONE  = AXIS_WIDTH'(1);

  // Next value of the counting sequence; wraps modulo 2^AXIS_WIDTH.
  function automatic logic [AXIS_WIDTH-1:0] data_inc(input logic [AXIS_WIDTH-1:0] v);
    return v + DATA_ONE;
  endfunction

  // Source stage
  logic                  src_valid_q, src_valid_d;
  logic [AXIS_WIDTH-1:0] src_data_q,  src_data_d;
  logic                  src_first_q, src_first_d;

  // Pipe stage: main register, skid register and registered s_tready
  logic                  pipe_s_ready_q, pipe_s_ready_d;
  logic                  main_valid_q, main_valid_d;
  logic [AXIS_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  main_first_q, main_first_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [AXIS_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  skid_first_q, skid_first_d;

  // Sink stage
  logic [1:0]            rdy_cnt_q,      rdy_cnt_d;
  logic                  expect_first_q, expect_first_d;
  logic [31:0]           beat_count_q,   beat_count_d;
  logic [AXIS_WIDTH-1:0] last_data_q,    last_data_d;
  logic                  seq_error_q,    seq_error_d;

  // Handshake qualifiers
  logic src_xfer_s;
  logic snk_ready_s;
  logic snk_xfer_s;

  // Transfer conditions on both internal links; sink ready drops one cycle in four.
  always_comb begin
    snk_ready_s = (rdy_cnt_q != 2'd3);
    src_xfer_s  = src_valid_q & pipe_s_ready_q;
    snk_xfer_s  = main_valid_q & snk_ready_s;
  end

  // Source: start a burst from init_data when idle, count up on each transfer,
  // and go idle after the pending beat is taken once en is low.
  always_comb begin
    src_valid_d = src_valid_q;
    src_data_d  = src_data_q;
    src_first_d = src_first_q;
    if (!src_valid_q) begin
      if (en) begin
        src_valid_d = 1'b1;
        src_data_d  = init_data;
        src_first_d = 1'b1;
      end else begin
        src_valid_d = 1'b0;
      end
    end else if (src_xfer_s) begin
      if (en) begin
        src_data_d  = data_inc(src_data_q);
        src_first_d = 1'b0;
      end else begin
        src_valid_d = 1'b0;
      end
    end else begin
      src_valid_d = 1'b1;
    end
  end

  // Pipe: main register refills from skid first, then from the input; an input
  // beat arriving while main is stalled parks in the skid register.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_first_d = main_first_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_first_d = skid_first_q;
    if (snk_xfer_s || !main_valid_q) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_first_d = skid_first_q;
        skid_valid_d = 1'b0;
      end else if (src_xfer_s) begin
        main_valid_d = 1'b1;
        main_data_d  = src_data_q;
        main_first_d = src_first_q;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (src_xfer_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = src_data_q;
        skid_first_d = src_first_q;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    pipe_s_ready_d = ~skid_valid_d;
  end

  // Sink: free-running ready counter, beat accounting and continuity check.
  always_comb begin
    rdy_cnt_d      = rdy_cnt_q + 2'd1;
    expect_first_d = expect_first_q;
    beat_count_d   = beat_count_q;
    last_data_d    = last_data_q;
    seq_error_d    = seq_error_q;
    if (snk_xfer_s) begin
      beat_count_d = beat_count_q + 32'd1;
      last_data_d  = main_data_q;
      if (main_first_q || expect_first_q) begin
        expect_first_d = 1'b0;
      end else if (main_data_q != data_inc(last_data_q)) begin
        seq_error_d = 1'b1;
      end else begin
        seq_error_d = seq_error_q;
      end
    end else begin
      beat_count_d = beat_count_q;
    end
  end

  // State registers for all three stages; reset discards any in-flight beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_valid_q    <= 1'b0;
      src_data_q     <= DATA_ZERO;
      src_first_q    <= 1'b0;
      pipe_s_ready_q <= 1'b0;
      main_valid_q   <= 1'b0;
      main_data_q    <= DATA_ZERO;
      main_first_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= DATA_ZERO;
      skid_first_q   <= 1'b0;
      rdy_cnt_q      <= 2'd0;
      expect_first_q <= 1'b1;
      beat_count_q   <= 32'd0;
      last_data_q    <= DATA_ZERO;
      seq_error_q    <= 1'b0;
    end else begin
      src_valid_q    <= src_valid_d;
      src_data_q     <= src_data_d;
      src_first_q    <= src_first_d;
      pipe_s_ready_q <= pipe_s_ready_d;
      main_valid_q   <= main_valid_d;
      main_data_q    <= main_data_d;
      main_first_q   <= main_first_d;
      skid_valid_q   <= skid_valid_d;
      skid_data_q    <= skid_data_d;
      skid_first_q   <= skid_first_d;
      rdy_cnt_q      <= rdy_cnt_d;
      expect_first_q <= expect_first_d;
      beat_count_q   <= beat_count_d;
      last_data_q    <= last_data_d;
      seq_error_q    <= seq_error_d;
    end
  end

  // Monitor and status outputs are taken straight from registers.
  always_comb begin
    mon_tvalid = main_valid_q;
    mon_tready = snk_ready_s;
    mon_tdata  = main_data_q;
    beat_count = beat_count_q;
    last_data  = last_data_q;
    seq_error  = seq_error_q;
  end

endmodule

// File: tb/tb_axis_stream_chain.sv
// Self-checking bench for axis_stream_chain: table of bursts (fixed + random)
// checked against a sequence-level model of the accepted beat stream.
module tb_axis_stream_chain;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         en;
  logic [W-1:0] init_data;
  logic         mon_tvalid;
  logic         mon_tready;
  logic [W-1:0] mon_tdata;
  logic [31:0]  beat_count;
  logic [W-1:0] last_data;
  logic         seq_error;

  axis_stream_chain #(.AXIS_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .init_data  (init_data),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tdata  (mon_tdata),
    .beat_count (beat_count),
    .last_data  (last_data),
    .seq_error  (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] init;
    int           cycles;
    logic [W-1:0] exp_first;
    logic [W-1:0] exp_second;
    int           exp_beats;   // 0: at least two beats, second checked
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  int checks   = 0;
  int failures = 0;

  // reference model of the accepted-beat stream
  int           mcnt;          // sink ready phase since reset release
  logic [31:0]  m_count;
  logic [W-1:0] m_last;
  logic         prev_stall;
  logic [W-1:0] prev_data;
  int           xfer_total;
  int           burst_id;
  int           seen_id;
  logic [W-1:0] burst_init;
  logic [W-1:0] burst_first;
  logic [W-1:0] burst_second;
  int           burst_beats;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [W-1:0] exp;
    @(negedge clk);
    if (!reset) begin
      mcnt       = 0;
      m_count    = 32'd0;
      m_last     = '0;
      prev_stall = 1'b0;
    end else begin
      chk(mon_tready == (mcnt != 3), "tready_pattern", 64'(mon_tready), 64'(mcnt != 3));
      chk(beat_count == m_count, "beat_count", 64'(beat_count), 64'(m_count));
      chk(last_data == m_last, "last_data", 64'(last_data), 64'(m_last));
      chk(seq_error == 1'b0, "seq_error", 64'(seq_error), 64'd0);
      if (prev_stall)
        chk(mon_tvalid && (mon_tdata == prev_data), "stall_hold", 64'(mon_tdata), 64'(prev_data));
      if (mon_tvalid && mon_tready) begin
        xfer_total++;
        if (burst_id != seen_id) begin
          seen_id     = burst_id;
          exp         = burst_init;
          burst_beats = 1;
          burst_first = mon_tdata;
        end else begin
          exp = m_last + 1'b1;
          burst_beats++;
          if (burst_beats == 2) burst_second = mon_tdata;
        end
        chk(mon_tdata == exp, "tdata_seq", 64'(mon_tdata), 64'(exp));
        m_count = m_count + 32'd1;
        m_last  = mon_tdata;
      end
      prev_stall = mon_tvalid && !mon_tready;
      prev_data  = mon_tdata;
      mcnt       = (mcnt + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int snap;
    init_data  = v.init;
    burst_init = v.init;
    burst_id++;
    en = 1'b1;
    for (int c = 0; c < v.cycles; c++) begin
      if (c == 6) snap = xfer_total;
      if (c == 22) chk((xfer_total - snap) == 12, "throughput_3of4", 64'(xfer_total - snap), 64'd12);
      tick();
    end
    en = 1'b0;
    repeat (8) tick();
    snap = xfer_total;
    repeat (8) tick();
    chk(xfer_total == snap, "no_extra_beat", 64'(xfer_total), 64'(snap));
    chk(burst_first == v.exp_first, "burst_first", 64'(burst_first), 64'(v.exp_first));
    if (v.exp_beats != 0) begin
      chk(burst_beats == v.exp_beats, "burst_beats", 64'(burst_beats), 64'(v.exp_beats));
    end else begin
      chk(burst_beats >= 2, "burst_min_beats", 64'(burst_beats), 64'd2);
      chk(burst_second == v.exp_second, "burst_second", 64'(burst_second), 64'(v.exp_second));
    end
  endtask

  initial begin
    logic [W-1:0] r;
    vecs[0] = '{32'd1,          25, 32'd1,          32'd2, 0};
    vecs[1] = '{32'd9,          12, 32'd9,          32'd10, 0};
    vecs[2] = '{32'hFFFF_FFFF,   8, 32'hFFFF_FFFF,  32'd0, 0};
    vecs[3] = '{32'h0000_0055,   1, 32'h0000_0055,  32'd0, 1};
    for (int i = 4; i < NVEC; i++) begin
      r = W'($urandom());
      vecs[i] = '{r, int'($urandom_range(20, 3)), r, r + 1'b1, 0};
    end

    mcnt = 0; m_count = 32'd0; m_last = '0; prev_stall = 1'b0; prev_data = '0;
    xfer_total = 0; burst_id = 0; seen_id = 0; burst_init = '0;
    burst_first = '0; burst_second = '0; burst_beats = 0;

    reset = 1'b1;
    en = 1'b0;
    init_data = '0;
    #2 reset = 1'b0;
    repeat (3) tick();
    chk(mon_tvalid == 1'b0, "rst_tvalid", 64'(mon_tvalid), 64'd0);
    chk(mon_tdata == '0, "rst_tdata", 64'(mon_tdata), 64'd0);
    chk(mon_tready == 1'b1, "rst_tready", 64'(mon_tready), 64'd1);
    chk(beat_count == 32'd0, "rst_beat_count", 64'(beat_count), 64'd0);
    chk(last_data == '0, "rst_last_data", 64'(last_data), 64'd0);
    chk(seq_error == 1'b0, "rst_seq_error", 64'(seq_error), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // mid-burst reset: in-flight beats vanish at once, then a clean restart
    init_data  = 32'd500;
    burst_init = 32'd500;
    burst_id++;
    en = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk(mon_tvalid == 1'b0, "midrst_tvalid", 64'(mon_tvalid), 64'd0);
    chk(beat_count == 32'd0, "midrst_beat_count", 64'(beat_count), 64'd0);
    chk(last_data == '0, "midrst_last_data", 64'(last_data), 64'd0);
    tick();
    tick();
    init_data  = 32'd77;
    burst_init = 32'd77;
    burst_id++;
    reset = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    repeat (10) tick();
    chk(burst_first == 32'd77, "midrst_first", 64'(burst_first), 64'd77);
    chk(beat_count == m_count && m_count > 32'd1, "midrst_count", 64'(beat_count), 64'(m_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
